// File: rtl/receptor_serial_abcd.sv
// Serial receiver for the A,B,C,D -> Z link: rebuilds the four-bit word from the
// single-wire frame (start, A, B, C, D, optional even parity, stop) and flags faults.
module receptor_serial_abcd #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic Z,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic valid,
  output logic parity_err,
  output logic frame_err,
  output logic busy
);

  localparam logic [7:0] CPB  = 8'(CLKS_PER_BIT);
  localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, BREAK
  } state_t;

  state_t      state;
  logic        z_meta, z_s, z_prev;
  logic [1:0]  fill;
  logic        line_ok;
  logic [7:0]  cnt;
  logic [1:0]  idx;
  logic [3:0]  sh;
  logic        p_bad;
  logic        tick;
  logic        start_edge;

  function automatic logic parity_bad(input logic [3:0] word, input logic pbit);
    return ^{word, pbit};
  endfunction

  assign tick = (cnt == 8'd1);
  // Edges only count once the synchroniser holds real line samples and the line
  // has been seen high, so a line held low through reset never starts a frame.
  assign start_edge = line_ok & z_prev & ~z_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_meta     <= 1'b1;
      z_s        <= 1'b1;
      z_prev     <= 1'b1;
      fill       <= 2'b00;
      line_ok    <= 1'b0;
      state      <= IDLE;
      cnt        <= 8'd0;
      idx        <= 2'd0;
      sh         <= 4'd0;
      p_bad      <= 1'b0;
      A          <= 1'b0;
      B          <= 1'b0;
      C          <= 1'b0;
      D          <= 1'b0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      z_meta     <= Z;
      z_s        <= z_meta;
      z_prev     <= z_s;
      fill       <= {fill[0], 1'b1};
      if (fill[1] && z_s) line_ok <= 1'b1;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start_edge) begin
            cnt   <= HALF;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 8'd1;
          end else if (z_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt   <= CPB;
            idx   <= 2'd0;
            state <= DATA;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 8'd1;
          end else begin
            sh  <= {sh[2:0], z_s};
            cnt <= CPB;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (!tick) begin
            cnt <= cnt - 8'd1;
          end else begin
            p_bad <= parity_bad(sh, z_s);
            cnt   <= CPB;
            state <= STOP;
          end
        end
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 8'd1;
          end else begin
            valid      <= 1'b1;
            frame_err  <= ~z_s;
            parity_err <= PARITY_EN & p_bad;
            if (z_s && !(PARITY_EN && p_bad)) {A, B, C, D} <= sh;
            state      <= DONE;
          end
        end
        DONE: begin
          // With two clocks per bit the next start bit lands exactly on this
          // cycle; a genuine edge (stop sampled high) is taken like in IDLE.
          if (start_edge) begin
            cnt   <= HALF;
            state <= START;
          end else if (z_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= BREAK;
          end
        end
        BREAK: begin
          if (z_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_serial_abcd.sv
// Directed bench for receptor_serial_abcd: default, 2-clock no-parity and
// 9-clock parity instances driven with hand-built frames.
module tb_receptor_serial_abcd;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  zl;
  logic [11:0] w_all;
  logic [2:0]  vld_o, pe_o, fe_o, busy_o;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          leak = 0;
  int          b_rise = 0;
  int          b_fall = 0;
  logic        b_prev = 1'b0;

  typedef struct {
    int         k;
    int         c;
    logic [3:0] w;
    logic       pe;
    logic       fe;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  receptor_serial_abcd #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .Z(zl[0]),
    .A(w_all[11]), .B(w_all[10]), .C(w_all[9]), .D(w_all[8]),
    .valid(vld_o[0]), .parity_err(pe_o[0]), .frame_err(fe_o[0]), .busy(busy_o[0])
  );

  receptor_serial_abcd #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) dut_c2 (
    .clk(clk), .rst(rst), .Z(zl[1]),
    .A(w_all[7]), .B(w_all[6]), .C(w_all[5]), .D(w_all[4]),
    .valid(vld_o[1]), .parity_err(pe_o[1]), .frame_err(fe_o[1]), .busy(busy_o[1])
  );

  receptor_serial_abcd #(.CLKS_PER_BIT(9), .PARITY_EN(1'b1)) dut_c9 (
    .clk(clk), .rst(rst), .Z(zl[2]),
    .A(w_all[3]), .B(w_all[2]), .C(w_all[1]), .D(w_all[0]),
    .valid(vld_o[2]), .parity_err(pe_o[2]), .frame_err(fe_o[2]), .busy(busy_o[2])
  );

  function automatic logic [3:0] wd(input int k);
    return w_all[11-4*k -: 4];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld_o[k]) evq.push_back('{k, cyc, wd(k), pe_o[k], fe_o[k]});
      else if (pe_o[k] || fe_o[k]) leak++;
    end
    if (busy_o[0] && !b_prev) b_rise = cyc;
    if (!busy_o[0] && b_prev) b_fall = cyc;
    b_prev = busy_o[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int k, input logic b, input int cpb);
    zl[k] = b;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input int cpb, input bit pe,
                            input logic [3:0] w, input logic par, input logic stp);
    drive_bit(k, 1'b0, cpb);
    for (int i = 3; i >= 0; i--) drive_bit(k, w[i], cpb);
    if (pe) drive_bit(k, par, cpb);
    drive_bit(k, stp, cpb);
  endtask

  function automatic int n_ev(input int k);
    int n = 0;
    foreach (evq[i]) if (evq[i].k == k) n++;
    return n;
  endfunction

  task automatic take(input int k, output ev_t e, output bit ok);
    int idx = -1;
    e = '{0, 0, 4'd0, 1'b0, 1'b0};
    foreach (evq[i]) if (idx < 0 && evq[i].k == k) idx = i;
    ok = (idx >= 0);
    if (ok) begin
      e = evq[idx];
      evq.delete(idx);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    bit  ok;
    int  s;

    rst = 1'b0;
    zl  = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {8'd0, w_all, vld_o, pe_o, fe_o, busy_o}, 32'd0);
    rst = 1'b1;
    repeat (5) sync();

    // clean frame 1011, even parity bit 1
    sync(); s = cyc;
    send_frame(0, 4, 1'b1, 4'b1011, 1'b1, 1'b1);
    repeat (4) sync();
    take(0, e, ok);
    chk("clean_seen", ok, 1);
    chk("clean_cycle", e.c, s + 29);
    chk("clean_word", e.w, 4'b1011);
    chk("clean_flags", {e.pe, e.fe}, 2'b00);
    chk("clean_busy_rise", b_rise, s + 3);
    chk("clean_busy_fall", b_fall, s + 30);

    // same word, wrong parity bit: output must hold 1011
    sync(); s = cyc;
    send_frame(0, 4, 1'b1, 4'b1011, 1'b0, 1'b1);
    repeat (4) sync();
    take(0, e, ok);
    chk("perr_seen", ok, 1);
    chk("perr_cycle", e.c, s + 29);
    chk("perr_flags", {e.pe, e.fe}, 2'b10);
    chk("perr_hold", wd(0), 4'b1011);

    // stop bit 0, line then held low ten bit times
    sync(); s = cyc;
    send_frame(0, 4, 1'b1, 4'b0110, 1'b0, 1'b0);
    repeat (40) sync();
    take(0, e, ok);
    chk("ferr_seen", ok, 1);
    chk("ferr_flags", {e.pe, e.fe}, 2'b01);
    chk("ferr_hold", wd(0), 4'b1011);
    chk("break_busy", busy_o[0], 1'b1);
    chk("break_no_frame", n_ev(0), 0);
    zl[0] = 1'b1;
    repeat (5) sync();
    chk("break_exit_busy", busy_o[0], 1'b0);
    sync(); s = cyc;
    send_frame(0, 4, 1'b1, 4'b0110, 1'b0, 1'b1);
    repeat (4) sync();
    take(0, e, ok);
    chk("after_break_cycle", e.c, s + 29);
    chk("after_break_word", {e.w, e.pe, e.fe}, {4'b0110, 2'b00});

    // one-cycle glitch
    evq.delete();
    sync(); s = cyc;
    zl[0] = 1'b0;
    sync();
    zl[0] = 1'b1;
    repeat (30) sync();
    chk("glitch_busy_rise", b_rise, s + 3);
    chk("glitch_busy_fall", b_fall, s + 5);
    chk("glitch_no_valid", n_ev(0), 0);

    // reset during data bit B, line held low across release
    sync();
    drive_bit(0, 1'b0, 4);
    drive_bit(0, 1'b1, 4);
    zl[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_outs", {wd(0), vld_o[0], pe_o[0], fe_o[0], busy_o[0]}, 8'd0);
    repeat (3) sync();
    rst = 1'b1;
    repeat (40) sync();
    chk("low_release_busy", busy_o[0], 1'b0);
    chk("low_release_no_valid", n_ev(0), 0);
    zl[0] = 1'b1;
    repeat (5) sync();
    sync(); s = cyc;
    send_frame(0, 4, 1'b1, 4'b1111, 1'b0, 1'b1);
    repeat (4) sync();
    chk("post_reset_count", n_ev(0), 1);
    take(0, e, ok);
    chk("post_reset_cycle", e.c, s + 29);
    chk("post_reset_word", {e.w, e.pe, e.fe}, {4'b1111, 2'b00});

    // CLKS_PER_BIT=2, no parity: 16 back-to-back frames
    evq.delete();
    sync(); s = cyc;
    for (int v = 0; v < 16; v++) send_frame(1, 2, 1'b0, 4'(v), 1'b0, 1'b1);
    repeat (5) sync();
    chk("c2_count", n_ev(1), 16);
    for (int v = 0; v < 16; v++) begin
      take(1, e, ok);
      if (v == 0) chk("c2_first_cycle", e.c, s + 14);
      chk($sformatf("c2_word%0d", v), {ok, e.w, e.pe, e.fe}, {1'b1, 4'(v), 2'b00});
    end

    // CLKS_PER_BIT=9, even parity: 16 back-to-back frames
    sync(); s = cyc;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] w;
      w = 4'(v);
      send_frame(2, 9, 1'b1, w, ^w, 1'b1);
    end
    repeat (12) sync();
    chk("c9_count", n_ev(2), 16);
    for (int v = 0; v < 16; v++) begin
      take(2, e, ok);
      if (v == 0) chk("c9_first_cycle", e.c, s + 61);
      chk($sformatf("c9_word%0d", v), {ok, e.w, e.pe, e.fe}, {1'b1, 4'(v), 2'b00});
    end
    chk("c9_last_out", wd(2), 4'b1111);

    chk("flags_without_valid", leak, 0);
    chk("stray_events", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
